// File: rtl/ak4619_pkg.sv
// Shared constants, sample type and frame-position helpers for the AK4619 TDM stage.
// Pure declarations: no logic, no latency, no backpressure.
// Frame position is always derived from the 8-bit 256fs counter through slot_of/bit_of.
package ak4619_pkg;

  localparam int N_CH       = 4;
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_CLKS = 256;
  localparam int SAMPLE_W   = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic logic [1:0] slot_of(input logic [7:0] cnt);
    return 2'(cnt >> 6);
  endfunction

  function automatic logic [4:0] bit_of(input logic [7:0] cnt);
    return 5'(cnt >> 1);
  endfunction

endpackage

// File: rtl/tdm_shift_lane.sv
// W-bit shift register lane: parallel load, MSB-first shift with serial fill, sync clear.
// Latency: one clk per load or shift.
// No backpressure: load_en has priority over shift_en; otherwise holds.
module tdm_shift_lane #(
  parameter int W = 16
) (
  input  logic         clk_256fs,
  input  logic         rst_n,
  input  logic         load_en,
  input  logic [W-1:0] load_dat,
  input  logic         shift_en,
  input  logic         shift_in,
  output logic [W-1:0] q
);

  always_ff @(posedge clk_256fs) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load_en) begin
      q <= load_dat;
    end else if (shift_en) begin
      q <= {q[W-2:0], shift_in};
    end
  end

endmodule

// File: rtl/ak4619_tdm_io.sv
// AK4619 TDM stage: BCLK/LRCK generation, 4-slot ADC capture to sample_in, 4-slot DAC launch from sample_out.
// Latency: ADC slot -> sample_in at the next frame wrap; sample_out latched at wrap and sent that frame.
// No backpressure, free-running on clk_256fs. Build option TDM_LOOPBACK_EN adds an ADC->DAC loopback port.
module ak4619_tdm_io
  import ak4619_pkg::N_CH, ak4619_pkg::FRAME_CLKS, ak4619_pkg::slot_of, ak4619_pkg::bit_of;
#(
  parameter int W         = 16,
  parameter int SLOT_BITS = ak4619_pkg::SLOT_BITS
) (
  input  logic                clk_256fs,
  input  logic                rst_n,
  output logic                bclk,
  output logic                lrck,
  input  logic                sdin,
  output logic                sdout,
  output logic                sample_clk,
`ifdef TDM_LOOPBACK_EN
  input  logic                loopback,
`endif
  output logic signed [W-1:0] sample_in0,
  output logic signed [W-1:0] sample_in1,
  output logic signed [W-1:0] sample_in2,
  output logic signed [W-1:0] sample_in3,
  input  logic signed [W-1:0] sample_out0,
  input  logic signed [W-1:0] sample_out1,
  input  logic signed [W-1:0] sample_out2,
  input  logic signed [W-1:0] sample_out3
);

  localparam int CAP_BITS = (W < SLOT_BITS) ? W : SLOT_BITS;

  logic [7:0]   cnt;
  logic [7:0]   cnt_nxt;
  logic         wrap;
  logic [W-1:0] adc_q    [N_CH];
  logic [W-1:0] dac_src  [N_CH];
  logic [W-1:0] dac_hold [N_CH];
  logic [W-1:0] dac_q;
  logic [W-1:0] dac_word;
  logic         dac_load;
  logic         dac_tail_unused;

  assign cnt_nxt = cnt + 8'd1;
  assign wrap    = (cnt == 8'(FRAME_CLKS - 1));

  // ADC: one lane per slot, fed on bclk rising (cnt even), only the first W bits of the slot.
  for (genvar k = 0; k < N_CH; k++) begin : g_adc
    logic cap_en;
    assign cap_en = ~cnt[0] && (slot_of(cnt) == 2'(k)) && (int'(bit_of(cnt)) < CAP_BITS);

    tdm_shift_lane #(.W(W)) u_lane (
      .clk_256fs (clk_256fs),
      .rst_n     (rst_n),
      .load_en   (1'b0),
      .load_dat  ('0),
      .shift_en  (cap_en),
      .shift_in  (sdin),
      .q         (adc_q[k])
    );
  end

  always_comb begin
    dac_src[0] = sample_out0;
    dac_src[1] = sample_out1;
    dac_src[2] = sample_out2;
    dac_src[3] = sample_out3;
`ifdef TDM_LOOPBACK_EN
    if (loopback) begin
      for (int k = 0; k < N_CH; k++) dac_src[k] = adc_q[k];
    end
`endif
  end

  // Slot 0 is launched on the same edge its word is latched, so it bypasses the holding register.
  always_comb begin
    dac_load = cnt[0] && (bit_of(cnt_nxt) == 5'd0);
    dac_word = wrap ? dac_src[0] : dac_hold[slot_of(cnt_nxt)];
  end

  tdm_shift_lane #(.W(W)) u_dac_lane (
    .clk_256fs (clk_256fs),
    .rst_n     (rst_n),
    .load_en   (dac_load),
    .load_dat  (dac_word),
    .shift_en  (cnt[0]),
    .shift_in  (1'b0),
    .q         (dac_q)
  );

  // The lane MSB is a flop that changes only on bclk falling; zero fill mutes bits W..31.
  assign sdout           = dac_q[W-1];
  assign dac_tail_unused = ^dac_q[W-2:0];

  always_ff @(posedge clk_256fs) begin
    if (!rst_n) begin
      cnt        <= '0;
      bclk       <= 1'b0;
      lrck       <= 1'b0;
      sample_clk <= 1'b0;
      sample_in0 <= '0;
      sample_in1 <= '0;
      sample_in2 <= '0;
      sample_in3 <= '0;
      for (int k = 0; k < N_CH; k++) dac_hold[k] <= '0;
    end else begin
      cnt        <= cnt_nxt;
      bclk       <= cnt_nxt[0];
      lrck       <= ~cnt_nxt[7];
      sample_clk <= cnt_nxt[7];
      if (wrap) begin
        sample_in0 <= adc_q[0];
        sample_in1 <= adc_q[1];
        sample_in2 <= adc_q[2];
        sample_in3 <= adc_q[3];
        for (int k = 0; k < N_CH; k++) dac_hold[k] <= dac_src[k];
      end
    end
  end

endmodule

// File: tb/tb_ak4619_tdm_io.sv
// Self-checking bench for ak4619_tdm_io: random codec frames and DAC words checked against a frame-level model.
`timescale 1ns/1ps
module tb_ak4619_tdm_io;
  import ak4619_pkg::*;

  localparam int W = SAMPLE_W;

  logic    clk_256fs = 1'b0;
  logic    rst_n     = 1'b0;
  logic    sdin      = 1'b0;
  logic    lb        = 1'b0;
  logic    bclk, lrck, sdout, sample_clk;
  sample_t sample_in0, sample_in1, sample_in2, sample_in3;
  sample_t so [4];
  sample_t si [4];

  assign si[0] = sample_in0;
  assign si[1] = sample_in1;
  assign si[2] = sample_in2;
  assign si[3] = sample_in3;

  always #5 clk_256fs = ~clk_256fs;

  ak4619_tdm_io #(.W(W)) dut (
    .clk_256fs   (clk_256fs),
    .rst_n       (rst_n),
    .bclk        (bclk),
    .lrck        (lrck),
    .sdin        (sdin),
    .sdout       (sdout),
    .sample_clk  (sample_clk),
`ifdef TDM_LOOPBACK_EN
    .loopback    (lb),
`endif
    .sample_in0  (sample_in0),
    .sample_in1  (sample_in1),
    .sample_in2  (sample_in2),
    .sample_in3  (sample_in3),
    .sample_out0 (so[0]),
    .sample_out1 (so[1]),
    .sample_out2 (so[2]),
    .sample_out3 (so[3])
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          c       = 0;
  bit          first   = 1'b1;
  bit          pend_vld = 1'b0;
  logic [31:0] adc_slots [4];
  logic [31:0] pend      [4];
  logic [31:0] dac_rx    [4];
  sample_t     exp_in    [4];
  sample_t     exp_dac   [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cnt %0d (t=%0t): got %h, expected %h", tag, c, $time, got, exp);
    end
  endtask

  task automatic load_next_frame();
    for (int k = 0; k < 4; k++) adc_slots[k] = pend_vld ? pend[k] : $urandom;
    pend_vld = 1'b0;
  endtask

  // One clk of the model: advance the frame position, apply frame-boundary rules, drive sdin, check.
  task automatic cycle();
    bit was_rst;
    was_rst = !rst_n;
    @(posedge clk_256fs);
    if (was_rst) begin
      c     = 0;
      first = 1'b1;
      for (int k = 0; k < 4; k++) begin
        exp_in[k]  = '0;
        exp_dac[k] = '0;
        dac_rx[k]  = '0;
      end
      load_next_frame();
    end else begin
      c     = (c + 1) % 256;
      first = 1'b0;
      if (c == 0) begin
        for (int k = 0; k < 4; k++)
          chk($sformatf("dac_slot%0d", k), dac_rx[k], {exp_dac[k], {(32-W){1'b0}}});
        for (int k = 0; k < 4; k++) begin
          exp_in[k]  = adc_slots[k][31 -: W];
          exp_dac[k] = lb ? exp_in[k] : so[k];
        end
        load_next_frame();
      end
    end
    #1;
    sdin = adc_slots[c / 64][31 - (c / 2) % 32];
    chk("bclk", 32'(bclk), c % 2);
    chk("lrck", 32'(lrck), 32'(!first && c < 128));
    chk("sample_clk", 32'(sample_clk), 32'(c >= 128));
    for (int k = 0; k < 4; k++) chk($sformatf("sample_in%0d", k), 32'(si[k]), 32'(exp_in[k]));
    if (first) chk("sdout_rst", 32'(sdout), 32'd0);
    if (c % 2 == 0) dac_rx[c / 64][31 - (c / 2) % 32] = sdout;
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    do begin
      cycle();
      guard++;
    end while (c != target && guard < 600);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      so[k]        = '0;
      adc_slots[k] = '0;
      dac_rx[k]    = '0;
      exp_in[k]    = '0;
      exp_dac[k]   = '0;
    end

    // Reset, then three free-running frames of random ADC data with muted DAC inputs.
    rst_n = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (3 * 256) cycle();

    // Directed ADC extremes with random low (ignored) slot bits.
    pend[0] = {16'h7FFF, 16'($urandom)};
    pend[1] = {16'h8000, 16'($urandom)};
    pend[2] = {16'h0001, 16'($urandom)};
    pend[3] = {16'hFFFF, 16'($urandom)};
    pend_vld = 1'b1;
    run_to(0);
    run_to(128);
    so[0] = 16'h1234; so[1] = 16'hABCD; so[2] = 16'h0000; so[3] = 16'h8001;
    run_to(0);
    chk("adc_pos_max", 32'(sample_in0), 32'(32767));
    chk("adc_neg_max", 32'(sample_in1), 32'(-32768));
    chk("adc_one",     32'(sample_in2), 32'(1));
    chk("adc_neg_one", 32'(sample_in3), 32'(-1));

    // Mid-frame sample_out change must not disturb the frame in progress.
    run_to(200);
    so[0] = 16'h0F0F; so[1] = 16'h7001; so[2] = 16'hFFFF; so[3] = 16'h0100;
    run_to(255);
    chk("adc_hold0", 32'(sample_in0), 32'(32767));
    chk("adc_hold1", 32'(sample_in1), 32'(-32768));
    chk("dac_dir0", dac_rx[0], 32'h1234_0000);
    chk("dac_dir1", dac_rx[1], 32'hABCD_0000);
    chk("dac_dir2", dac_rx[2], 32'h0000_0000);
    chk("dac_dir3", dac_rx[3], 32'h8001_0000);
    run_to(255);
    chk("dac_new0", dac_rx[0], 32'h0F0F_0000);
    chk("dac_new2", dac_rx[2], 32'hFFFF_0000);

    // Random DAC words changed at random points in random ADC frames.
    repeat (6) begin
      run_to($urandom_range(1, 255));
      for (int k = 0; k < 4; k++) so[k] = sample_t'($urandom);
      run_to(0);
    end

    // Reset mid-frame: restart at cnt 0, first frame muted, no stale capture.
    run_to(90);
    rst_n = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    run_to(255);
    chk("dac_mute0", dac_rx[0], 32'h0);
    chk("dac_mute3", dac_rx[3], 32'h0);
    run_to(0);
    run_to(0);
    run_to(10);

`ifdef TDM_LOOPBACK_EN
    // Loopback: ADC slot2 reappears on DAC slot2 one frame later; mid-frame deassert waits for the wrap.
    lb = 1'b1;
    for (int k = 0; k < 4; k++) pend[k] = $urandom;
    pend[2] = {16'h4000, 16'($urandom)};
    pend_vld = 1'b1;
    run_to(0);
    run_to(0);
    run_to(50);
    lb = 1'b0;
    run_to(255);
    chk("lb_slot2", dac_rx[2], 32'h4000_0000);
    run_to(0);
    run_to(0);
`endif

    run_to(0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
